lsu_byte_port: RTL and testbench

LSU_BYTE_PORT -- requirements
Module: lsu_byte_port

---
 rtl/lsu_byte_port_if.sv | 29 ++
 rtl/lsu_byte_port.sv | 107 ++++++++++
 tb/tb_lsu_byte_port.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_port_if.sv
// Bundle for the LSU byte port: pipeline request/response and byte-wide data-memory signals.
// The master side is the pipeline plus memory; the slave side is the LSU.
interface lsu_byte_port_if #(
   parameter int ADDR_W = 9
);
   logic              req_valid;
   logic              req_we;
   logic [2:0]        req_type;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              busy;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (
      output req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
      input  busy, done, rdata, err, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_wdata, mem_rdata,
      output busy, done, rdata, err, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_byte_port.sv
// Load/store unit that serialises word, halfword and byte accesses into single-byte
// beats on a byte-wide data memory, with sign/zero extension of load results.
module lsu_byte_port #(
   parameter int ADDR_W = 9
) (
   input  logic            clk,
   input  logic            rstn,
   lsu_byte_port_if.slave  bus
);

   localparam logic [2:0] T_WORD  = 3'b000;
   localparam logic [2:0] T_HALF  = 3'b001;
   localparam logic [2:0] T_HALFU = 3'b010;
   localparam logic [2:0] T_BYTE  = 3'b011;
   localparam logic [2:0] T_BYTEU = 3'b100;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic              we_q;
   logic [2:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        beat_q;
   logic [1:0]        last_q;
   logic              illegal_q;
   logic [31:0]       rdata_q;

   function automatic logic [1:0] last_beat(input logic [2:0] typ);
      case (typ)
         T_WORD:          return 2'd3;
         T_HALF, T_HALFU: return 2'd1;
         default:         return 2'd0;
      endcase
   endfunction

   // Extension is reapplied every beat; only the value after the final beat is architectural.
   function automatic logic [31:0] merge_load(input logic [31:0] cur, input logic [2:0] typ,
                                              input logic [1:0] beat, input logic [7:0] b);
      logic [31:0] r;
      r = cur;
      r[{beat, 3'b000} +: 8] = b;
      case (typ)
         T_HALF:  r = {{16{r[15]}}, r[15:0]};
         T_HALFU: r = {16'h0000, r[15:0]};
         T_BYTE:  r = {{24{b[7]}}, b};
         T_BYTEU: r = {24'h000000, b};
         default: r = r;
      endcase
      return r;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         type_q    <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         beat_q    <= 2'd0;
         last_q    <= 2'd0;
         illegal_q <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q      <= bus.req_we;
                  type_q    <= bus.req_type;
                  addr_q    <= bus.req_addr;
                  wdata_q   <= bus.req_wdata;
                  beat_q    <= 2'd0;
                  last_q    <= last_beat(bus.req_type);
                  illegal_q <= (bus.req_type > T_BYTEU);
                  rdata_q   <= 32'h0;
                  state     <= (bus.req_type > T_BYTEU) ? DONE : ACCESS;
               end
            end
            ACCESS: begin
               if (!we_q) rdata_q <= merge_load(rdata_q, type_q, beat_q, bus.mem_rdata);
               if (beat_q == last_q) state <= DONE;
               else                  beat_q <= beat_q + 2'd1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no latch is inferred on the non-ACCESS paths.
   always_comb begin
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
      bus.err       = (state == DONE) && illegal_q;
      bus.rdata     = rdata_q;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 8'h00;
      if (state == ACCESS) begin
         bus.mem_we    = we_q;
         bus.mem_addr  = addr_q + ADDR_W'(beat_q);
         bus.mem_wdata = we_q ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;
      end
   end

endmodule

// File: tb/tb_lsu_byte_port.sv
// Directed self-checking bench for lsu_byte_port with a 512-byte behavioural memory.
module tb_lsu_byte_port;

   logic clk = 1'b0;
   logic rstn;
   int   n_checks = 0;
   int   n_fail   = 0;

   lsu_byte_port_if #(.ADDR_W(9)) bus ();

   lsu_byte_port #(.ADDR_W(9)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [512];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, then walk its beats, the done cycle and the following idle cycle.
   task automatic do_op(input string tag, input logic we, input logic [2:0] typ,
                        input logic [8:0] addr, input logic [31:0] wd, input int n,
                        input logic [31:0] exp_rd, input logic exp_err);
      logic [8:0] ea;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_type = typ;
      bus.req_addr = addr; bus.req_wdata = wd;
      @(negedge clk);
      bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_type = 3'b111;
      bus.req_addr = ~addr; bus.req_wdata = ~wd;
      for (int k = 0; k < n; k++) begin
         ea = addr + 9'(k);
         check({tag, " busy"}, 32'(bus.busy), 32'd1);
         check({tag, " done early"}, 32'(bus.done), 32'd0);
         check({tag, " mem_we"}, 32'(bus.mem_we), 32'(we));
         check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(ea));
         if (we) check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(wd[8*k +: 8]));
         @(negedge clk);
      end
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " err"}, 32'(bus.err), 32'(exp_err));
      check({tag, " done mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, " done mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, " rdata"}, bus.rdata, exp_rd);
      @(negedge clk);
      check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
      check({tag, " idle done"}, 32'(bus.done), 32'd0);
      check({tag, " idle err"}, 32'(bus.err), 32'd0);
      check({tag, " rdata hold"}, bus.rdata, exp_rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt, idle_cnt, run, max_run, viol, bad_rd;
      rstn = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 3'b000;
      bus.req_addr = '0; bus.req_wdata = 32'h0;

      @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst err", 32'(bus.err), 32'd0);
      check("rst rdata", bus.rdata, 32'h0);
      check("rst mem_we", 32'(bus.mem_we), 32'd0);
      check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
      rstn = 1'b1;

      do_op("sw", 1'b1, 3'b000, 9'h010, 32'hDEADBEEF, 4, 32'h0, 1'b0);
      check("sw mem10", 32'(mem[9'h010]), 32'hEF);
      check("sw mem11", 32'(mem[9'h011]), 32'hBE);
      check("sw mem12", 32'(mem[9'h012]), 32'hAD);
      check("sw mem13", 32'(mem[9'h013]), 32'hDE);

      do_op("lb", 1'b0, 3'b011, 9'h010, 32'h0, 1, 32'hFFFFFFEF, 1'b0);
      do_op("lbu", 1'b0, 3'b100, 9'h010, 32'h0, 1, 32'h000000EF, 1'b0);
      do_op("lw", 1'b0, 3'b000, 9'h010, 32'h0, 4, 32'hDEADBEEF, 1'b0);

      do_op("sb1ff", 1'b1, 3'b011, 9'h1FF, 32'hAABBCC34, 1, 32'h0, 1'b0);
      do_op("sb000", 1'b1, 3'b100, 9'h000, 32'h11223382, 1, 32'h0, 1'b0);
      check("sb1ff mem", 32'(mem[9'h1FF]), 32'h34);
      check("sb000 mem", 32'(mem[9'h000]), 32'h82);
      do_op("lh wrap", 1'b0, 3'b001, 9'h1FF, 32'h0, 2, 32'hFFFF8234, 1'b0);
      do_op("lhu wrap", 1'b0, 3'b010, 9'h1FF, 32'h0, 2, 32'h00008234, 1'b0);

      do_op("illegal", 1'b1, 3'b110, 9'h040, 32'h12345678, 0, 32'h0, 1'b1);

      do_op("sw zero", 1'b1, 3'b000, 9'h020, 32'h0, 4, 32'h0, 1'b0);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_type = 3'b000;
      bus.req_addr = 9'h020; bus.req_wdata = 32'h11223344;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort beat2 addr", 32'(bus.mem_addr), 32'h022);
      rstn = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort mem_we", 32'(bus.mem_we), 32'd0);
      check("abort mem_addr", 32'(bus.mem_addr), 32'd0);
      check("abort mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("abort rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check("abort no done", 32'(done_cnt), 32'd0);
      check("abort mem20", 32'(mem[9'h020]), 32'h44);
      check("abort mem21", 32'(mem[9'h021]), 32'h33);
      check("abort mem22", 32'(mem[9'h022]), 32'h00);
      check("abort mem23", 32'(mem[9'h023]), 32'h00);

      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_type = 3'b011;
      bus.req_addr = 9'h010; bus.req_wdata = 32'h0;
      done_cnt = 0; idle_cnt = 0; run = 0; max_run = 0; viol = 0; bad_rd = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            if (bus.rdata !== 32'hFFFFFFEF) bad_rd++;
         end
         if (!bus.busy) begin
            idle_cnt++;
            run++;
            if (run > max_run) max_run = run;
         end else run = 0;
         if ((!bus.busy || bus.done) && (bus.mem_we || bus.mem_addr != 0 || bus.mem_wdata != 0)) viol++;
      end
      bus.req_valid = 1'b0;
      check("stream done count", 32'(done_cnt), 32'd10);
      check("stream idle count", 32'(idle_cnt), 32'd10);
      check("stream max idle run", 32'(max_run), 32'd1);
      check("stream mem idle viol", 32'(viol), 32'd0);
      check("stream rdata", 32'(bad_rd), 32'd0);
      @(negedge clk);
      check("stream end busy", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
